// File: rtl/ahbl_bus_arbiter.sv
// Round-robin AHB-Lite bus arbiter: grants at transfer boundaries, holds through bursts and
// locked sequences, muxes address phase by address owner and HWDATA by data-phase owner.
module ahbl_bus_arbiter #(
  parameter int  NUM_MASTERS = 4,
  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [NUM_MASTERS-1:0]    M_HBUSREQ,
  input  logic [NUM_MASTERS-1:0]    M_HLOCK,
  input  logic [32*NUM_MASTERS-1:0] M_HADDR,
  input  logic [2*NUM_MASTERS-1:0]  M_HTRANS,
  input  logic [NUM_MASTERS-1:0]    M_HWRITE,
  input  logic [3*NUM_MASTERS-1:0]  M_HSIZE,
  input  logic [3*NUM_MASTERS-1:0]  M_HBURST,
  input  logic [4*NUM_MASTERS-1:0]  M_HPROT,
  input  logic [32*NUM_MASTERS-1:0] M_HWDATA,
  output logic [NUM_MASTERS-1:0]    M_HGRANT,
  output logic [31:0]               HADDR,
  output logic [1:0]                HTRANS,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic [3:0]                HPROT,
  output logic                      HMASTLOCK,
  output logic [31:0]               HWDATA,
  output logic [MW-1:0]             HMASTER,
  input  logic                      HREADY,
  input  logic                      HRESP
);

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

  typedef struct packed {
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
  } ap_t;

  ap_t [NUM_MASTERS-1:0]             ap;
  logic [NUM_MASTERS-1:0][31:0]      wd;
  ap_t                               cur;
  logic [MW-1:0]                     addr_owner, data_owner, owner_nx, idx;
  logic [4:0]                        beat_cnt, beat_nx;
  logic                              hold, hold_nx, found;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
    assign ap[i] = {M_HADDR[32*i +: 32], M_HTRANS[2*i +: 2], M_HWRITE[i],
                    M_HSIZE[3*i +: 3], M_HBURST[3*i +: 3], M_HPROT[4*i +: 4]};
    assign wd[i] = M_HWDATA[32*i +: 32];
  end

  assign cur       = ap[addr_owner];
  assign HADDR     = cur.haddr;
  assign HTRANS    = cur.htrans;
  assign HWRITE    = cur.hwrite;
  assign HSIZE     = cur.hsize;
  assign HBURST    = cur.hburst;
  assign HPROT     = cur.hprot;
  assign HMASTLOCK = M_HLOCK[addr_owner] & (cur.htrans != T_IDLE);
  assign HWDATA    = wd[data_owner];
  assign HMASTER   = addr_owner;

  always_comb begin
    M_HGRANT             = '0;
    M_HGRANT[addr_owner] = 1'b1;
  end

  // Burst tracking on the owner's signals; hold_nx is the post-edge hold, so a
  // release and a new grant land on the same edge.
  always_comb begin
    hold_nx = hold;
    beat_nx = beat_cnt;
    case (cur.htrans)
      T_NONSEQ: begin
        case (cur.hburst)
          3'b000:         begin hold_nx = 1'b0; beat_nx = 5'd0;  end
          3'b001:         begin hold_nx = 1'b1; beat_nx = 5'd0;  end
          3'b010, 3'b011: begin hold_nx = 1'b1; beat_nx = 5'd3;  end
          3'b100, 3'b101: begin hold_nx = 1'b1; beat_nx = 5'd7;  end
          default:        begin hold_nx = 1'b1; beat_nx = 5'd15; end
        endcase
      end
      T_SEQ: begin
        if (beat_cnt > 5'd1) beat_nx = beat_cnt - 5'd1;
        else if (beat_cnt == 5'd1) begin
          beat_nx = 5'd0;
          hold_nx = 1'b0;
        end
      end
      T_BUSY:  ;
      default: hold_nx = 1'b0;
    endcase
    // An undefined-length burst ends when its master stops requesting.
    if (hold_nx && beat_nx == 5'd0 && !M_HBUSREQ[addr_owner] && cur.htrans != T_BUSY)
      hold_nx = 1'b0;
    if (HRESP) begin
      hold_nx = 1'b0;
      beat_nx = 5'd0;
    end
  end

  // Search starts one past the owner, so the owner itself is checked last.
  always_comb begin
    owner_nx = addr_owner;
    found    = 1'b0;
    idx      = addr_owner;
    if (!hold_nx && !M_HLOCK[addr_owner]) begin
      for (int i = 1; i <= NUM_MASTERS; i++) begin
        idx = MW'((int'(addr_owner) + i) % NUM_MASTERS);
        if (!found && M_HBUSREQ[idx]) begin
          found    = 1'b1;
          owner_nx = idx;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_owner <= '0;
      data_owner <= '0;
      beat_cnt   <= '0;
      hold       <= 1'b0;
    end else if (HREADY) begin
      addr_owner <= owner_nx;
      data_owner <= addr_owner;
      beat_cnt   <= beat_nx;
      hold       <= hold_nx;
    end
  end

endmodule

// File: tb/tb_ahbl_bus_arbiter.sv
// Directed table-driven bench for ahbl_bus_arbiter (4 masters): each row is one cycle's inputs
// plus the owner/data-owner expected before that cycle's closing edge.
module tb_ahbl_bus_arbiter;

  localparam int N = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [N-1:0]  M_HBUSREQ, M_HLOCK, M_HWRITE, M_HGRANT;
  logic [32*N-1:0] M_HADDR, M_HWDATA;
  logic [2*N-1:0]  M_HTRANS;
  logic [3*N-1:0]  M_HSIZE, M_HBURST;
  logic [4*N-1:0]  M_HPROT;
  logic [31:0]   HADDR, HWDATA;
  logic [1:0]    HTRANS, HMASTER;
  logic          HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]    HSIZE, HBURST;
  logic [3:0]    HPROT;

  ahbl_bus_arbiter #(.NUM_MASTERS(N)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .M_HBUSREQ(M_HBUSREQ), .M_HLOCK(M_HLOCK),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HBURST(M_HBURST), .M_HPROT(M_HPROT), .M_HWDATA(M_HWDATA), .M_HGRANT(M_HGRANT),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HMASTER(HMASTER),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  localparam logic [1:0] ID = 2'b00, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SGL = 3'b000, INC = 3'b001, I4 = 3'b011, I8 = 3'b101, W16 = 3'b110;

  typedef struct {
    logic       rst;
    logic [3:0] req, lck;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       rdy, rsp;
    logic [1:0] mst, dmst;
    logic       mlk;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0, n_bad = 0;

  function automatic vec_t mk(logic rst, logic [3:0] req, logic [3:0] lck, logic [1:0] tr,
                              logic [2:0] bu, logic rdy, logic rsp, logic [1:0] mst,
                              logic [1:0] dmst, logic mlk);
    vec_t v;
    v.rst = rst; v.req = req; v.lck = lck; v.tr = tr; v.bu = bu; v.rdy = rdy; v.rsp = rsp;
    v.mst = mst; v.dmst = dmst; v.mlk = mlk;
    return v;
  endfunction

  task automatic chk32(string nm, int row, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  initial begin
    logic [3:0] eg;
    for (int i = 0; i < N; i++) begin
      M_HADDR[32*i +: 32]  = 32'hA000_0000 | i;
      M_HWDATA[32*i +: 32] = 32'hD000_0000 | i;
    end
    M_HWRITE = '1; M_HSIZE = {N{3'b010}}; M_HPROT = {N{4'b0011}};
    M_HBUSREQ = '0; M_HLOCK = '0; M_HTRANS = '0; M_HBURST = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRESET = 1'b1;
    repeat (2) @(posedge HCLK);

    // parked on master 0 with no requests
    for (int i = 0; i < 10; i++) vq.push_back(mk(0, 4'b0000, 0, ID, SGL, 1, 0, 0, 0, 0));
    // alternating singles between masters 1 and 3
    vq.push_back(mk(0, 4'b1010, 0, NS, SGL, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b1010, 0, NS, SGL, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 4'b1010, 0, NS, SGL, 1, 0, 3, 1, 0));
    vq.push_back(mk(0, 4'b1010, 0, NS, SGL, 1, 0, 1, 3, 0));
    vq.push_back(mk(0, 4'b0001, 0, ID, SGL, 1, 0, 3, 1, 0));
    // master 0 INCR4 with two wait states, master 2 waiting
    vq.push_back(mk(0, 4'b0101, 0, NS, I4,  1, 0, 0, 3, 0));
    vq.push_back(mk(0, 4'b0101, 0, SQ, I4,  1, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0101, 0, SQ, I4,  0, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0101, 0, SQ, I4,  0, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0101, 0, SQ, I4,  1, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0101, 0, SQ, I4,  1, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'b0010, 0, ID, SGL, 1, 0, 2, 0, 0));
    // master 1 locked singles, master 0 requesting
    vq.push_back(mk(0, 4'b0011, 4'b0010, NS, SGL, 1, 0, 1, 2, 1));
    vq.push_back(mk(0, 4'b0011, 4'b0010, NS, SGL, 1, 0, 1, 1, 1));
    vq.push_back(mk(0, 4'b0011, 4'b0010, ID, SGL, 1, 0, 1, 1, 0));
    vq.push_back(mk(0, 4'b0011, 4'b0000, NS, SGL, 1, 0, 1, 1, 0));
    vq.push_back(mk(0, 4'b0100, 0, ID, SGL, 1, 0, 0, 1, 0));
    // master 2 INCR8 error on beat 3, master 3 waiting
    vq.push_back(mk(0, 4'b1100, 0, NS, I8, 1, 0, 2, 0, 0));
    vq.push_back(mk(0, 4'b1100, 0, SQ, I8, 1, 0, 2, 2, 0));
    vq.push_back(mk(0, 4'b1100, 0, SQ, I8, 1, 1, 2, 2, 0));
    // master 3 WRAP16 abandoned by reset
    vq.push_back(mk(0, 4'b1000, 0, NS, W16, 1, 0, 3, 2, 0));
    vq.push_back(mk(0, 4'b1000, 0, SQ, W16, 1, 0, 3, 3, 0));
    vq.push_back(mk(1, 4'b1000, 0, SQ, W16, 1, 0, 3, 3, 0));
    vq.push_back(mk(0, 4'b1000, 0, SQ, W16, 1, 0, 0, 0, 0));
    // master 3 INCR released by dropping its request, master 0 wins at once
    vq.push_back(mk(0, 4'b1001, 0, NS, INC, 1, 0, 3, 0, 0));
    vq.push_back(mk(0, 4'b1001, 0, SQ, INC, 1, 0, 3, 3, 0));
    vq.push_back(mk(0, 4'b0001, 0, SQ, INC, 1, 0, 3, 3, 0));
    vq.push_back(mk(0, 4'b0000, 0, ID, SGL, 1, 0, 0, 3, 0));
    vq.push_back(mk(0, 4'b0000, 0, ID, SGL, 1, 0, 0, 0, 0));

    foreach (vq[r]) begin
      @(negedge HCLK);
      HRESET = vq[r].rst; M_HBUSREQ = vq[r].req; M_HLOCK = vq[r].lck;
      M_HTRANS = {N{vq[r].tr}}; M_HBURST = {N{vq[r].bu}};
      HREADY = vq[r].rdy; HRESP = vq[r].rsp;
      #1;
      eg = 4'b0001 << vq[r].mst;
      chk32("grant",   r, 32'(M_HGRANT),  32'(eg));
      chk32("hmaster", r, 32'(HMASTER),   32'(vq[r].mst));
      chk32("haddr",   r, HADDR,          32'hA000_0000 | 32'(vq[r].mst));
      chk32("hwdata",  r, HWDATA,         32'hD000_0000 | 32'(vq[r].dmst));
      chk32("mastlock", r, 32'(HMASTLOCK), 32'(vq[r].mlk));
    end

    @(negedge HCLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahbl_bus_arbiter.md
Name: ahbl_bus_arbiter

Overview:
- Shares one AHB-Lite slave-side bus between NUM_MASTERS requesting masters, e.g. several BFM instances or a BFM plus a DMA engine.
- Round-robin arbitration at transfer boundaries; holds the grant for the whole of a fixed-length burst, an INCR burst or a locked sequence.
- Multiplexes address-phase signals by the address-phase owner and HWDATA by the data-phase owner.
- Sits between the masters and the address decoder / slave mux.

Parameters:
NUM_MASTERS, 4, number of masters (2..8); sets vector widths and MW = clog2(NUM_MASTERS), minimum 1.

Ports:
HCLK  in  1  bus clock; all state on rising edge
HRESET  in  1  synchronous active-high reset
M_HBUSREQ  in  NUM_MASTERS  per-master bus request
M_HLOCK  in  NUM_MASTERS  per-master lock request
M_HADDR  in  32*NUM_MASTERS  packed, master i at [32i+31:32i]
M_HTRANS  in  2*NUM_MASTERS  packed
M_HWRITE  in  NUM_MASTERS
M_HSIZE  in  3*NUM_MASTERS
M_HBURST  in  3*NUM_MASTERS
M_HPROT  in  4*NUM_MASTERS
M_HWDATA  in  32*NUM_MASTERS
M_HGRANT  out  NUM_MASTERS  one-hot address-phase grant
HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT  out  32/2/1/3/3/4  muxed address phase
HMASTLOCK  out  1  M_HLOCK of the owner while the owner's HTRANS != IDLE
HWDATA  out  32  muxed by data-phase owner
HMASTER  out  MW  address-phase owner index
HREADY  in  1  slave-side ready, broadcast to all masters outside this block
HRESP  in  1  slave-side error response

Behaviour:
- State:
  - addr_owner (MW bits), data_owner (MW bits).
  - beat_cnt (5 bits): beats remaining in the current fixed-length burst.
  - hold flag.
- Reset (HRESET=1 at edge): addr_owner=0, data_owner=0, beat_cnt=0, hold=0, M_HGRANT=...0001, HMASTER=0.
- A reset asserted mid-burst abandons the burst; there is no completion.
- Muxed outputs are combinational from the owner registers, so there is zero added latency on address or data.
- All state updates only on edges where HREADY=1. With HREADY=0, every register holds.
- Burst tracking (owner's signals, HREADY=1 edge):
  - NONSEQ with HBURST INCR4/WRAP4: beat_cnt=3, hold=1. INCR8/WRAP8: beat_cnt=7, hold=1. INCR16/WRAP16: beat_cnt=15, hold=1.
  - NONSEQ with INCR (001): hold=1, beat_cnt=0.
  - NONSEQ with SINGLE: hold=0.
  - SEQ: if beat_cnt>1, decrement. If beat_cnt==1, set beat_cnt=0 and hold=0. If beat_cnt==0, the burst is INCR; hold stays 1.
  - BUSY: no change.
  - IDLE: hold=0.
  - An INCR burst releases hold when the owner drives IDLE or a NONSEQ SINGLE, or when M_HBUSREQ[owner] drops while HTRANS != BUSY.
- Lock: while M_HLOCK[owner]=1, the grant never moves, regardless of hold.
- Error: HRESP=1 with HREADY=1 clears hold and beat_cnt. Arbitration proceeds at that same edge.
- Arbitration (HREADY=1 edge, hold=0, lock=0, or the hold-release conditions met at this edge):
  - Search M_HBUSREQ starting at addr_owner+1, wrapping modulo NUM_MASTERS; the first requester wins.
  - If the owner is the only requester, it keeps the grant.
  - If nobody requests, park on the current owner.
  - New owner takes effect for the address phase of the next cycle.
- data_owner <= addr_owner on every HREADY=1 edge (one-cycle lag), so HWDATA follows the pipelined data phase.
- Simultaneous hold release and new requests: release and arbitrate at the same edge. There is no dead cycle.
- A requester whose index equals addr_owner is considered last in rotation (fairness).

Test Plan:
1. Reset, no requests, HREADY=1 -> M_HGRANT=0001, HMASTER=0, stays parked for 10 cycles.
2. M_HBUSREQ=1010, all SINGLE NONSEQ writes, HREADY=1 -> grants alternate master1, master3, master1…; HWDATA equals the previous cycle's owner's M_HWDATA.
3. Master0 issues INCR4 (NONSEQ + 3 SEQ) while master2 requests -> grant stays 0 for 4 beats and moves to 2 on the edge ending beat 4; with HREADY=0 for 2 cycles mid-burst, the grant still moves only after beat 4.
4. Master1 M_HLOCK=1 across two SINGLE transfers, master0 requesting -> HMASTLOCK=1, grant held on 1 until M_HLOCK drops, then 0 is granted.
5. Master2 INCR8 with HRESP=1, HREADY=1 on beat 3, master3 requesting -> grant moves to 3 at that edge; beat_cnt=0.
6. HRESET asserted mid-WRAP16 burst of master3 -> next cycle M_HGRANT=0001, HMASTER=0, HWDATA sourced from master0.
